wb_boot_ctl: RTL and testbench

Wishbone slave for bus slot 0 of the picorv32 USB SoC. It replaces the bare warm-boot register with three functions: a keyed boot request, a programmable countdown before the boot fires, and a debounced button with a long-press auto-boot. It drives `boot_now` / `boot_sel` into the warm-boot helper and reports the debounced button level back to firmware.

---
 rtl/boot_ctl_pkg.sv | 27 ++
 rtl/wb_boot_ctl_debounce.sv | 47 ++++
 rtl/wb_boot_ctl.sv | 160 ++++++++++++++++
 tb/tb_wb_boot_ctl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_ctl_pkg.sv
// Shared definitions for the warm-boot controller: FSM encoding,
// register map, unlock key and CSR bit positions.
package boot_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } boot_state_e;

  // Word addresses on the bus slot
  localparam logic [1:0] REG_CSR   = 2'd0;
  localparam logic [1:0] REG_DELAY = 2'd1;

  // Unlock key expected in CSR[15:8] on every software boot command
  localparam logic [7:0] BOOT_KEY = 8'hA5;

  // CSR field positions
  localparam int CSR_SEL_LSB    = 0;
  localparam int CSR_REQ_BIT    = 2;
  localparam int CSR_ARMED_BIT  = 2;
  localparam int CSR_FIRED_BIT  = 3;
  localparam int CSR_BTN_BIT    = 4;
  localparam int CSR_LP_BIT     = 5;
  localparam int CSR_KEY_LSB    = 8;

endpackage

// File: rtl/wb_boot_ctl_debounce.sv
// Button conditioner: 2-FF synchronizer on the inverted (active-low) pad,
// then a stability counter that flips the output only after the
// synchronized level has disagreed with it for 2^DEB_W straight cycles.
module btn_debounce #(
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic val
);

  logic             sync1_q, sync2_q;
  logic             val_q;
  logic [DEB_W-1:0] cnt_q;

  // Synchronize the asynchronous pad; pressed (pad low) becomes 1
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, making the 2-FF chain real.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ~pad;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive disagreeing cycles; any bounce back restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      val_q <= 1'b0;
    end else if (sync2_q == val_q) begin
      cnt_q <= '0;
    end else if (&cnt_q) begin
      cnt_q <= '0;
      val_q <= ~val_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/wb_boot_ctl.sv
// Wishbone slot-0 warm-boot controller: keyed boot request with a
// programmable countdown, debounced button readback and (optionally)
// long-press auto-boot.
// Optional feature macro: BOOT_CTL_LONGPRESS_EN enables the long-press
// counter; without it FIRE is reachable only from software.
module wb_boot_ctl
  import boot_ctl_pkg::*;
#(
  parameter int         DW      = 32,
  parameter int         DELAY_W = 24,
  parameter int         DEB_W   = 16,
  parameter int         LP_W    = 24,
  parameter logic [1:0] LP_SEL  = 2'b01
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    wb_addr,
  output logic [DW-1:0] wb_rdata,
  input  logic [DW-1:0] wb_wdata,
  input  logic          wb_we,
  input  logic          wb_cyc,
  output logic          wb_ack,
  input  logic          btn_pad,
  output logic          btn_val,
  output logic          boot_now,
  output logic [1:0]    boot_sel
);

  boot_state_e        state_q, state_d;
  logic [DELAY_W-1:0] delay_q, cnt_q, cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               ack_q;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               btn_val_w;
  logic               lp_sat, lp_active;
  logic               armed, fired;
  logic               acc, wr_en, key_wr, wr_req;
  logic               unused_bits;

  btn_debounce #(.DEB_W(DEB_W)) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .pad   (btn_pad),
    .val   (btn_val_w)
  );

  // A new access is the first cycle of wb_cyc; FIRE locks out all writes
  assign acc    = wb_cyc & ~ack_q;
  assign wr_en  = acc & wb_we & (state_q != ST_FIRE);
  assign key_wr = wr_en && (wb_addr == REG_CSR) &&
                  (wb_wdata[CSR_KEY_LSB +: 8] == BOOT_KEY);
  assign wr_req = wb_wdata[CSR_REQ_BIT];

`ifdef BOOT_CTL_LONGPRESS_EN
  logic [LP_W-1:0] lp_cnt_q;

  // Long-press timer: runs while pressed, holds at all-ones, clears on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               lp_cnt_q <= '0;
    else if (!btn_val_w)      lp_cnt_q <= '0;
    else if (!(&lp_cnt_q))    lp_cnt_q <= lp_cnt_q + 1'b1;
  end

  assign lp_sat      = &lp_cnt_q;
  assign lp_active   = |lp_cnt_q;
  assign unused_bits = ^wb_wdata;
`else
  assign lp_sat      = 1'b0;
  assign lp_active   = 1'b0;
  assign unused_bits = ^wb_wdata ^ (^LP_SEL) ^ LP_W[0];
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; long-press overrides any software command
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (key_wr && wr_req) state_d = ST_ARMED;
      ST_ARMED: begin
        if (key_wr)           state_d = wr_req ? ST_ARMED : ST_IDLE;
        else if (cnt_q == '0) state_d = ST_FIRE;
      end
      ST_FIRE:  state_d = ST_FIRE;
      default:  state_d = ST_IDLE;
    endcase
    if (lp_sat && (state_q != ST_FIRE)) state_d = ST_FIRE;
  end

  // FSM outputs
  always_comb begin
    armed    = (state_q == ST_ARMED);
    fired    = (state_q == ST_FIRE);
    boot_now = fired;
  end

  // Countdown and image select next values
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (armed && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    if (key_wr) begin
      sel_d = wb_wdata[CSR_SEL_LSB +: 2];
      if (wr_req) cnt_d = delay_q;
    end
    if (lp_sat && !fired) sel_d = LP_SEL;
  end

  // Datapath registers; DELAY writes only change the reload value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      delay_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      if (wr_en && (wb_addr == REG_DELAY)) delay_q <= wb_wdata[DELAY_W-1:0];
    end
  end

  // Read mux; data is presented only alongside ack
  always_comb begin
    rdata_d = '0;
    if (acc) begin
      if (wb_addr == REG_CSR) begin
        rdata_d[CSR_SEL_LSB +: 2] = sel_q;
        rdata_d[CSR_ARMED_BIT]    = armed;
        rdata_d[CSR_FIRED_BIT]    = fired;
        rdata_d[CSR_BTN_BIT]      = btn_val_w;
        rdata_d[CSR_LP_BIT]       = lp_active;
      end else if (wb_addr == REG_DELAY) begin
        rdata_d = DW'(armed ? cnt_q : delay_q);
      end
    end
  end

  // Single-wait-state acknowledge with registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= acc;
      rdata_q <= rdata_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_rdata = rdata_q;
  assign btn_val  = btn_val_w;
  assign boot_sel = sel_q;

endmodule

// File: tb/tb_wb_boot_ctl.sv
// Directed bench for wb_boot_ctl: register-map vectors from a table, then
// hand-written timed sequences for countdown, cancel, button and reset.
module tb_wb_boot_ctl;

  localparam int         DW      = 32;
  localparam int         DELAY_W = 24;
  localparam int         DEB_W   = 4;
  localparam int         LP_W    = 8;
  localparam logic [1:0] LP_SEL  = 2'b01;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    wb_addr;
  logic [DW-1:0] wb_rdata;
  logic [DW-1:0] wb_wdata;
  logic          wb_we;
  logic          wb_cyc;
  logic          wb_ack;
  logic          btn_pad;
  logic          btn_val;
  logic          boot_now;
  logic [1:0]    boot_sel;

  always #5 clk = ~clk;

  wb_boot_ctl #(
    .DW(DW), .DELAY_W(DELAY_W), .DEB_W(DEB_W), .LP_W(LP_W), .LP_SEL(LP_SEL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_addr  (wb_addr),
    .wb_rdata (wb_rdata),
    .wb_wdata (wb_wdata),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack),
    .btn_pad  (btn_pad),
    .btn_val  (btn_val),
    .boot_now (boot_now),
    .boot_sel (boot_sel)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: one access, sampled at the following negedge,
  // then one idle cycle so ack has dropped before the next access.
  task automatic wb_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic ack_seen,
                         output logic ack_after, output logic [31:0] rdata_after);
    wb_cyc = 1'b1; wb_we = we; wb_addr = addr; wb_wdata = wdata;
    @(negedge clk);
    ack_seen = wb_ack;
    rdata    = wb_rdata;
    wb_cyc = 1'b0; wb_we = 1'b0; wb_wdata = '0;
    @(negedge clk);
    ack_after   = wb_ack;
    rdata_after = wb_rdata;
  endtask

  task automatic wb_write(input string name, input logic [1:0] addr, input logic [31:0] wdata);
    logic [31:0] rd, rd2;
    logic        ak, ak2;
    wb_xfer(1'b1, addr, wdata, rd, ak, ak2, rd2);
    check({name, "_ack"}, {31'd0, ak}, 32'd1);
  endtask

  task automatic wb_read_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] rd, rd2;
    logic        ak, ak2;
    wb_xfer(1'b0, addr, 32'd0, rd, ak, ak2, rd2);
    check({name, "_ack"}, {31'd0, ak}, 32'd1);
    check(name, rd, exp);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = 2'd0; wb_wdata = '0;
    btn_pad = 1'b1;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(1);
  endtask

  vec_t vecs[14];

  initial begin
    logic [31:0] rd, rd2;
    logic        ak, ak2;
    logic        seen;

    vecs[0]  = '{"rst_csr",     1'b0, 2'd0, 32'h0,        32'h0};
    vecs[1]  = '{"rst_delay",   1'b0, 2'd1, 32'h0,        32'h0};
    vecs[2]  = '{"wr_delay",    1'b1, 2'd1, 32'd1000,     32'h0};
    vecs[3]  = '{"delay_rb",    1'b0, 2'd1, 32'h0,        32'd1000};
    vecs[4]  = '{"wr_badkey",   1'b1, 2'd0, 32'h00000006, 32'h0};
    vecs[5]  = '{"badkey_csr",  1'b0, 2'd0, 32'h0,        32'h0};
    vecs[6]  = '{"wr_nearkey",  1'b1, 2'd0, 32'h0000A406, 32'h0};
    vecs[7]  = '{"nearkey_csr", 1'b0, 2'd0, 32'h0,        32'h0};
    vecs[8]  = '{"wr_reg2",     1'b1, 2'd2, 32'hFFFFFFFF, 32'h0};
    vecs[9]  = '{"reg2_rd",     1'b0, 2'd2, 32'h0,        32'h0};
    vecs[10] = '{"wr_reg3",     1'b1, 2'd3, 32'hFFFFFFFF, 32'h0};
    vecs[11] = '{"reg3_rd",     1'b0, 2'd3, 32'h0,        32'h0};
    vecs[12] = '{"wr_delay_max",1'b1, 2'd1, 32'h12FFFFFF, 32'h0};
    vecs[13] = '{"delay_trunc", 1'b0, 2'd1, 32'h0,        32'h00FFFFFF};

    do_reset();
    check("rst_boot_now", {31'd0, boot_now}, 32'd0);
    check("rst_boot_sel", {30'd0, boot_sel}, 32'd0);
    check("rst_btn_val",  {31'd0, btn_val},  32'd0);
    check("rst_ack",      {31'd0, wb_ack},   32'd0);

    // Register map vectors (all in IDLE)
    for (int i = 0; i < 14; i++) begin
      wb_xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, ak, ak2, rd2);
      check({vecs[i].name, "_ack"}, {31'd0, ak}, 32'd1);
      check({vecs[i].name, "_ackdrop"}, {31'd0, ak2}, 32'd0);
      check({vecs[i].name, "_idle_rdata"}, rd2, 32'h0);
      if (!vecs[i].we) check(vecs[i].name, rd, vecs[i].exp_rdata);
    end
    check("idle_boot_now", {31'd0, boot_now}, 32'd0);

    // Countdown: DELAY=5, boot_now rises after write edge E + 6
    do_reset();
    wb_write("a_delay", 2'd1, 32'd5);
    wb_write("a_arm", 2'd0, 32'h0000A506);          // returns after E+1
    check("a_boot_sel", {30'd0, boot_sel}, 32'd2);
    wb_read_chk("a_csr_armed", 2'd0, 32'h00000006); // returns after E+3
    wait_neg(2);                                    // after E+5
    check("a_boot_now_e5", {31'd0, boot_now}, 32'd0);
    wait_neg(1);                                    // after E+6
    check("a_boot_now_e6", {31'd0, boot_now}, 32'd1);
    wb_read_chk("a_csr_fired", 2'd0, 32'h0000000A);
    wb_write("a_fire_wr", 2'd0, 32'h0000A500);
    wb_read_chk("a_csr_locked", 2'd0, 32'h0000000A);
    check("a_boot_now_held", {31'd0, boot_now}, 32'd1);

    // Asynchronous reset in FIRE while ack is high
    wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 2'd0;
    @(posedge clk);
    #2;
    check("r_ack_pre", {31'd0, wb_ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("r_ack_async",      {31'd0, wb_ack},   32'd0);
    check("r_boot_now_async", {31'd0, boot_now}, 32'd0);
    check("r_boot_sel_async", {30'd0, boot_sel}, 32'd0);
    wb_cyc = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_neg(1);

    // Cancel: DELAY=1000, live count readback, cancel around count 500
    wb_write("b_delay", 2'd1, 32'd1000);
    wb_write("b_arm", 2'd0, 32'h0000A505);          // returns after E+1
    wait_neg(9);                                    // after E+10
    wb_read_chk("b_live_cnt", 2'd1, 32'd990);       // sampled at E+11
    wait_neg(487);
    wb_write("b_cancel", 2'd0, 32'h0000A502);
    seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (boot_now) seen = 1'b1;
    end
    check("b_no_fire", {31'd0, seen}, 32'd0);
    wb_read_chk("b_delay_rb", 2'd1, 32'd1000);
    wb_read_chk("b_csr_idle", 2'd0, 32'h00000002);

    // DELAY written while ARMED must not disturb the running count
    do_reset();
    wb_write("c_delay", 2'd1, 32'd20);
    wb_write("c_arm", 2'd0, 32'h0000A504);          // returns after E+1
    wb_write("c_delay2", 2'd1, 32'd2);              // returns after E+3
    wait_neg(17);                                   // after E+20
    check("c_boot_now_e20", {31'd0, boot_now}, 32'd0);
    wait_neg(1);                                    // after E+21
    check("c_boot_now_e21", {31'd0, boot_now}, 32'd1);

    // DELAY=0 fires on the edge after the write edge
    do_reset();
    wb_write("d_arm", 2'd0, 32'h0000A507);          // returns after E+1
    check("d_boot_now", {31'd0, boot_now}, 32'd1);
    check("d_boot_sel", {30'd0, boot_sel}, 32'd3);

    // Button: short glitch is rejected, held press debounces after 18 cycles
    do_reset();
    btn_pad = 1'b0;
    wait_neg(10);
    btn_pad = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (btn_val) seen = 1'b1;
    end
    check("e_glitch_reject", {31'd0, seen}, 32'd0);
    btn_pad = 1'b0;
    wait_neg(17);
    check("e_btn_val_17", {31'd0, btn_val}, 32'd0);
    wait_neg(1);                                    // btn_val rose at edge 18
    check("e_btn_val_18", {31'd0, btn_val}, 32'd1);
    wb_read_chk("e_csr_btn", 2'd0, 32'h00000010);   // returns after edge 20
    wait_neg(253);                                  // after edge 273
    check("e_lp_pre", {31'd0, boot_now}, 32'd0);
    wait_neg(1);                                    // after edge 274
`ifdef BOOT_CTL_LONGPRESS_EN
    check("e_lp_boot_now", {31'd0, boot_now}, 32'd1);
    check("e_lp_boot_sel", {30'd0, boot_sel}, {30'd0, LP_SEL});
`else
    seen = boot_now;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (boot_now) seen = 1'b1;
    end
    check("e_no_lp_fire", {31'd0, seen}, 32'd0);
    check("e_no_lp_sel", {30'd0, boot_sel}, 32'd0);
`endif
    btn_pad = 1'b1;
    wait_neg(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
